mbisr_repair_ctrl: RTL and testbench
====================================

# mbisr_repair_ctrl

Built-in self-repair stage directly downstream of the MBIST engine in the MBIST/MBISR macro. It consumes the failing addresses reported by the MBIST engine and holds them in a small fully-associative remap table, one entry per spare word. It then sits between the functional access port and the 32-word main array, redirecting any access to a logged address into an internal spare register file. It reports repair status (spares used, unrepairable) to the top-level outputs.

## Interface
- `ADDR_W`, default 5: array address width (32 words).
- `DATA_W`, default 8: data word width.
- `NUM_SPARES`, default 4: spare words and remap entries; must be ≥1.
- `CNT_W`, default 3: width of `used_count`; equals clog2(`NUM_SPARES`+1).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  one-cycle pulse, issued at MBIST start; empties the remap table and clears `repair_fail`.
- `log_valid`  in  1  MBIST fail report strobe.
- `log_addr`  in  ADDR_W  failing address; qualified by `log_valid`.
- `repair_en`  in  1  1 = remap active; 0 = bypass (raw array, used while MBIST runs).
- `mem_req`  in  1  functional access request.
- `mem_we`  in  1  1 = write, 0 = read.
- `mem_addr`  in  ADDR_W  functional address.
- `mem_wdata`  in  DATA_W  write data.
- `array_req`  out  1  request to main array (registered).
- `array_we`  out  1  array write enable (registered).
- `array_addr`  out  ADDR_W  array address (registered).
- `array_wdata`  out  DATA_W  array write data (registered).
- `array_rdata`  in  DATA_W  array read data; valid 1 cycle after `array_req` with `array_we`=0.
- `rd_valid`  out  1  read data valid pulse.
- `rd_data`  out  DATA_W  read data (registered).
- `used_count`  out  CNT_W  spare entries allocated.
- `repair_fail`  out  1  sticky: a new fail address arrived with no free spare.

## Operation
- Remap table: `NUM_SPARES` entries of {valid, addr}. Entry i maps to spare word i. Entries fill in index order; the next free index is always `used_count`.
- Log handling, per cycle:
  - If `clear`=1: all valid bits are cleared, `used_count`=0, `repair_fail`=0. A simultaneous `log_valid` is dropped.
  - Else if `log_valid` and `log_addr` matches a valid entry: no change. MBIST reports the same address from several march elements, so duplicates are expected.
  - Else if `log_valid` and `used_count` < `NUM_SPARES`: entry[`used_count`] = {1, `log_addr`}, and `used_count` increments.
  - Else if `log_valid`: `repair_fail` is set and stays set until `clear` or reset. The table is unchanged.
- Lookup:
  - Hit = `repair_en` & any valid entry whose addr equals `mem_addr`.
  - Lookup uses the table state before the current edge. An entry logged in cycle N affects requests from cycle N+1.
- Write on hit: the spare word at the hit index is updated at the request edge. `array_req` stays 0 in the following cycle.
- Write on miss: `array_req`/`array_we`/`array_addr`/`array_wdata` are registered from the request.
- Read on hit: the spare word is captured into the pipeline. `array_req` stays 0.
- Read on miss: `array_req`=1 and `array_we`=0 are registered.
- Read pipeline: a 2-stage valid/hit/spare-data shift. In stage 2, `rd_data` is registered from `array_rdata` on a miss, or from the delayed spare data on a hit.
- Spare register file: not cleared by `clear`. Contents are undefined for functional use after `clear`.

## Timing
- Reset (async assert, sync release): all table valid bits=0, `used_count`=0, `repair_fail`=0, spare words=0, `array_req`=0, `array_we`=0, `array_addr`=0, `array_wdata`=0, `rd_valid`=0, `rd_data`=0, all pipeline valids=0.
- Reset during an access: in-flight reads are discarded and `rd_valid` does not assert for them.
- Request accepted every cycle; no backpressure.
- Miss path: request at edge N → `array_req` high N+1 → `array_rdata` valid N+2 → `rd_valid`/`rd_data` at N+3.
- Hit reads also return at N+3, so reads always complete in order with a fixed 3-cycle latency.
- Hit writes take effect at edge N. A hit read issued at N+1 returns the new data.
- `used_count` and `repair_fail` update on the edge after `log_valid`.
- Duplicate detection compares against the table state at the log edge. Two consecutive logs of the same new address produce exactly one entry.

## Test plan
1. Reset then release → all outputs 0. A read of addr 3 with `repair_en`=1 gives `array_req`=1, `array_addr`=3 one cycle later, and `rd_valid` 3 cycles after the request with `rd_data`=`array_rdata`.
2. Log addrs 5, 9, 5, 9 on consecutive cycles → `used_count`=2, `repair_fail`=0.
3. Log 0,1,2,3,4 → `used_count`=4 after the 4th log, `repair_fail`=1 after the 5th. Then `clear` → `used_count`=0, `repair_fail`=0.
4. With 9 logged and `repair_en`=1: write 0xA5 to addr 9 → no `array_req`. Read addr 9 → `rd_valid` at +3 with `rd_data`=0xA5. With `repair_en`=0, the same read goes to the array.
5. `clear` and `log_valid`(addr 7) in the same cycle → `used_count`=0. A subsequent read of addr 7 reaches the array.
6. Read of addr 3 issued, then `rst_n` asserted 1 cycle later and released → `rd_valid` stays 0 and all outputs return to reset values.

Source files
------------

// File: rtl/mbisr_repair_ctrl.sv
// Built-in self-repair controller: logs MBIST fail addresses into a small
// fully-associative remap table and redirects functional accesses that hit
// a logged address into a spare register file. Reads return with a fixed
// 3-cycle latency whether they hit a spare or go to the main array.
module mbisr_repair_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int NUM_SPARES = 4,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              log_valid,
    input  logic [ADDR_W-1:0] log_addr,
    input  logic              repair_en,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              array_req,
    output logic              array_we,
    output logic [ADDR_W-1:0] array_addr,
    output logic [DATA_W-1:0] array_wdata,
    input  logic [DATA_W-1:0] array_rdata,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  used_count,
    output logic              repair_fail
);

    // Remap table and spare storage; entry i owns spare word i.
    logic [NUM_SPARES-1:0] tbl_valid_reg;
    logic [ADDR_W-1:0]     tbl_addr_reg [NUM_SPARES];
    logic [DATA_W-1:0]     spare_reg    [NUM_SPARES];
    logic [CNT_W-1:0]      used_count_reg;
    logic                  repair_fail_reg;

    // Output and read-pipeline registers.
    logic              array_req_reg;
    logic              array_we_reg;
    logic [ADDR_W-1:0] array_addr_reg;
    logic [DATA_W-1:0] array_wdata_reg;
    logic              rd_v1_reg, rd_v2_reg;
    logic              rd_h1_reg, rd_h2_reg;
    logic [DATA_W-1:0] rd_d1_reg, rd_d2_reg;
    logic              rd_valid_reg;
    logic [DATA_W-1:0] rd_data_reg;

    logic [NUM_SPARES-1:0] log_match;
    logic [NUM_SPARES-1:0] lookup_match;
    logic                  log_dup;
    logic                  log_room;
    logic                  log_alloc;
    logic                  lookup_hit;
    logic [DATA_W-1:0]     spare_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPARES; gi++) begin : g_entry
            // Both compares use the table as it stood before this edge.
            assign log_match[gi]    = tbl_valid_reg[gi] && (tbl_addr_reg[gi] == log_addr);
            assign lookup_match[gi] = repair_en && tbl_valid_reg[gi] && (tbl_addr_reg[gi] == mem_addr);

            // Table entry: filled in index order at position used_count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tbl_valid_reg[gi] <= 1'b0;
                    tbl_addr_reg[gi]  <= '0;
                end else if (clear) begin
                    tbl_valid_reg[gi] <= 1'b0;
                end else if (log_alloc && (used_count_reg == CNT_W'(gi))) begin
                    tbl_valid_reg[gi] <= 1'b1;
                    tbl_addr_reg[gi]  <= log_addr;
                end
            end

            // Spare word: written by a functional write that hits this entry.
            // Deliberately untouched by clear.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    spare_reg[gi] <= '0;
                end else if (mem_req && mem_we && lookup_match[gi]) begin
                    spare_reg[gi] <= mem_wdata;
                end
            end
        end
    endgenerate

    assign log_dup    = |log_match;
    assign log_room   = used_count_reg < CNT_W'(NUM_SPARES);
    assign log_alloc  = log_valid && !clear && !log_dup && log_room;
    assign lookup_hit = |lookup_match;

    // Spare read mux; entries never alias, so at most one match is set.
    always_comb begin
        spare_rdata = '0;
        for (int i = 0; i < NUM_SPARES; i++) begin
            if (lookup_match[i]) begin
                spare_rdata = spare_rdata | spare_reg[i];
            end
        end
    end

    // Allocation count and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_count_reg  <= '0;
            repair_fail_reg <= 1'b0;
        end else if (clear) begin
            used_count_reg  <= '0;
            repair_fail_reg <= 1'b0;
        end else if (log_alloc) begin
            used_count_reg  <= used_count_reg + CNT_W'(1);
        end else if (log_valid && !log_dup) begin
            repair_fail_reg <= 1'b1;
        end
    end

    // Main-array request: only misses are forwarded; address/data hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            array_req_reg   <= 1'b0;
            array_we_reg    <= 1'b0;
            array_addr_reg  <= '0;
            array_wdata_reg <= '0;
        end else begin
            array_req_reg <= mem_req && !lookup_hit;
            array_we_reg  <= mem_req && mem_we && !lookup_hit;
            if (mem_req && !lookup_hit) begin
                array_addr_reg  <= mem_addr;
                array_wdata_reg <= mem_wdata;
            end
        end
    end

    // Two-stage read pipeline so hit and miss reads share one latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1_reg    <= 1'b0;
            rd_v2_reg    <= 1'b0;
            rd_h1_reg    <= 1'b0;
            rd_h2_reg    <= 1'b0;
            rd_d1_reg    <= '0;
            rd_d2_reg    <= '0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            rd_v1_reg    <= mem_req && !mem_we;
            rd_h1_reg    <= lookup_hit;
            rd_d1_reg    <= spare_rdata;
            rd_v2_reg    <= rd_v1_reg;
            rd_h2_reg    <= rd_h1_reg;
            rd_d2_reg    <= rd_d1_reg;
            rd_valid_reg <= rd_v2_reg;
            if (rd_v2_reg) begin
                rd_data_reg <= rd_h2_reg ? rd_d2_reg : array_rdata;
            end
        end
    end

    assign array_req   = array_req_reg;
    assign array_we    = array_we_reg;
    assign array_addr  = array_addr_reg;
    assign array_wdata = array_wdata_reg;
    assign rd_valid    = rd_valid_reg;
    assign rd_data     = rd_data_reg;
    assign used_count  = used_count_reg;
    assign repair_fail = repair_fail_reg;

endmodule

// File: tb/tb_mbisr_repair_ctrl.sv
// Testbench for mbisr_repair_ctrl: the bench models the main array, keeps a
// reference model of the remap table and memory contents, and scores every
// read return against a queue of expected data.
module tb_mbisr_repair_ctrl;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int NSP    = 4;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              log_valid;
    logic [ADDR_W-1:0] log_addr;
    logic              repair_en;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              array_req;
    logic              array_we;
    logic [ADDR_W-1:0] array_addr;
    logic [DATA_W-1:0] array_wdata;
    logic [DATA_W-1:0] array_rdata;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  used_count;
    logic              repair_fail;

    int total = 0;
    int bad   = 0;

    // Bench-side array storage and reference model.
    logic [DATA_W-1:0] arr_mem   [32];
    logic [DATA_W-1:0] arr_exp   [32];
    logic [DATA_W-1:0] spare_exp [32];
    bit                m_logged  [32];
    int                m_used;
    bit                m_fail;
    logic [DATA_W-1:0] exp_q [$];

    mbisr_repair_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SPARES(NSP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .log_valid(log_valid), .log_addr(log_addr), .repair_en(repair_en),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .array_req(array_req), .array_we(array_we), .array_addr(array_addr),
        .array_wdata(array_wdata), .array_rdata(array_rdata),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .used_count(used_count), .repair_fail(repair_fail)
    );

    always #5 clk = ~clk;

    // Main array: synchronous write, registered read.
    always @(posedge clk) begin
        if (array_req) begin
            if (array_we) arr_mem[array_addr] <= array_wdata;
            else          array_rdata <= arr_mem[array_addr];
        end
    end

    // Scoreboard: every read return must match the oldest expected value.
    always @(negedge clk) begin
        if (rd_valid) begin
            logic [DATA_W-1:0] e;
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL rd_unexpected: rd_valid with data %02h, nothing outstanding", rd_data);
                bad++;
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    $display("FAIL rd_data: got %02h want %02h", rd_data, e);
                    bad++;
                end else begin
                    $display("read return %02h ok", rd_data);
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
        if (repair_en && m_logged[a]) return spare_exp[a];
        return arr_exp[a];
    endfunction

    function automatic bit model_hit(input logic [ADDR_W-1:0] a);
        return repair_en && m_logged[a];
    endfunction

    // One functional access held for exactly one cycle; returns at edge+1.
    task automatic access(input bit we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input bit expect_ret);
        mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = d;
        if (we) begin
            if (model_hit(a)) spare_exp[a] = d;
            else              arr_exp[a]   = d;
        end else if (expect_ret) begin
            exp_q.push_back(model_read(a));
        end
        $display("access we=%0b addr=%0d data=%02h hit=%0b", we, a, d, model_hit(a));
        @(posedge clk); #1;
        mem_req = 1'b0; mem_we = 1'b0;
    endtask

    // One MBIST fail report, with the reference table updated alongside.
    task automatic do_log(input logic [ADDR_W-1:0] a);
        log_valid = 1'b1; log_addr = a;
        if (!m_logged[a]) begin
            if (m_used < NSP) begin m_logged[a] = 1'b1; m_used++; end
            else m_fail = 1'b1;
        end
        $display("log addr=%0d", a);
        @(posedge clk); #1;
        log_valid = 1'b0;
    endtask

    task automatic do_clear(input bit with_log, input logic [ADDR_W-1:0] a);
        clear = 1'b1; log_valid = with_log; log_addr = a;
        for (int i = 0; i < 32; i++) m_logged[i] = 1'b0;
        m_used = 0; m_fail = 1'b0;
        $display("clear with_log=%0b addr=%0d", with_log, a);
        @(posedge clk); #1;
        clear = 1'b0; log_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        total++;
        if (used_count !== CNT_W'(m_used)) begin
            $display("FAIL %s used_count: got %0d want %0d", tag, used_count, m_used);
            bad++;
        end
        total++;
        if (repair_fail !== m_fail) begin
            $display("FAIL %s repair_fail: got %0b want %0b", tag, repair_fail, m_fail);
            bad++;
        end
    endtask

    task automatic check_outputs_idle(input string tag);
        logic [31:0] got;
        got = {array_req, array_we, array_addr, array_wdata, rd_valid, rd_data,
               used_count, repair_fail, 4'b0};
        total++;
        if (got !== 32'd0) begin
            $display("FAIL %s outputs: got %08h want 00000000", tag, got);
            bad++;
        end else begin
            $display("%s outputs all zero", tag);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_idle("reset_hold");
        rst_n = 1'b1;
        idle(1);
        check_outputs_idle("reset_release");
    endtask

    task automatic test_miss_read();
        repair_en = 1'b1;
        access(1'b0, 5'd3, 8'h00, 1'b1);
        total++;
        if ({array_req, array_we, array_addr} !== {1'b1, 1'b0, 5'd3}) begin
            $display("FAIL miss_req: got req=%0b we=%0b addr=%0d want req=1 we=0 addr=3",
                     array_req, array_we, array_addr);
            bad++;
        end
        idle(1);
        total++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL miss_early: rd_valid got %0b want 0 at +2", rd_valid);
            bad++;
        end
        idle(1);
        total++;
        if (rd_valid !== 1'b1) begin
            $display("FAIL miss_latency: rd_valid got %0b want 1 at +3", rd_valid);
            bad++;
        end
        idle(2);
    endtask

    task automatic test_dup_log();
        do_log(5'd5); do_log(5'd9); do_log(5'd5); do_log(5'd9);
        check_status("dup_log");
    endtask

    task automatic test_overflow();
        do_clear(1'b0, 5'd0);
        do_log(5'd0); do_log(5'd1); do_log(5'd2); do_log(5'd3);
        check_status("fill4");
        do_log(5'd4);
        check_status("overflow");
        do_log(5'd2);
        check_status("dup_when_full");
        do_clear(1'b0, 5'd0);
        check_status("after_clear");
    endtask

    task automatic test_hit_rw();
        do_log(5'd9);
        repair_en = 1'b1;
        access(1'b1, 5'd9, 8'hA5, 1'b0);
        total++;
        if (array_req !== 1'b0) begin
            $display("FAIL hit_write_req: array_req got %0b want 0", array_req);
            bad++;
        end
        access(1'b0, 5'd9, 8'h00, 1'b1);
        total++;
        if (array_req !== 1'b0) begin
            $display("FAIL hit_read_req: array_req got %0b want 0", array_req);
            bad++;
        end
        repair_en = 1'b0;
        access(1'b0, 5'd9, 8'h00, 1'b1);
        total++;
        if ({array_req, array_addr} !== {1'b1, 5'd9}) begin
            $display("FAIL bypass_req: got req=%0b addr=%0d want req=1 addr=9",
                     array_req, array_addr);
            bad++;
        end
        repair_en = 1'b1;
        access(1'b1, 5'd10, 8'h77, 1'b0);
        total++;
        if ({array_req, array_we, array_addr, array_wdata} !== {1'b1, 1'b1, 5'd10, 8'h77}) begin
            $display("FAIL miss_write: got req=%0b we=%0b addr=%0d wdata=%02h want 1 1 10 77",
                     array_req, array_we, array_addr, array_wdata);
            bad++;
        end
        access(1'b0, 5'd10, 8'h00, 1'b1);
        idle(4);
    endtask

    task automatic test_clear_log();
        do_clear(1'b1, 5'd7);
        check_status("clear_with_log");
        access(1'b0, 5'd7, 8'h00, 1'b1);
        total++;
        if ({array_req, array_addr} !== {1'b1, 5'd7}) begin
            $display("FAIL clear_drop_req: got req=%0b addr=%0d want req=1 addr=7",
                     array_req, array_addr);
            bad++;
        end
        idle(4);
    endtask

    task automatic test_back_to_back();
        do_log(5'd12); do_log(5'd12);
        check_status("consec_dup");
        do_log(5'd20);
        // Entry logged in the previous cycle must already redirect this write.
        access(1'b1, 5'd20, 8'h3C, 1'b0);
        access(1'b1, 5'd12, 8'h5A, 1'b0);
        access(1'b0, 5'd12, 8'h00, 1'b1);
        access(1'b0, 5'd3,  8'h00, 1'b1);
        access(1'b0, 5'd20, 8'h00, 1'b1);
        access(1'b0, 5'd10, 8'h00, 1'b1);
        access(1'b1, 5'd12, 8'hC3, 1'b0);
        access(1'b0, 5'd12, 8'h00, 1'b1);
        for (int k = 0; k < 6; k++) begin
            logic [ADDR_W-1:0] a;
            a = ADDR_W'($urandom_range(0, 31));
            access(1'b0, a, 8'h00, 1'b1);
        end
        idle(5);
        check_status("b2b_final");
    endtask

    task automatic test_reset_inflight();
        access(1'b0, 5'd3, 8'h00, 1'b0);
        idle(1);
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) m_logged[i] = 1'b0;
        m_used = 0; m_fail = 1'b0;
        #2;
        check_outputs_idle("inflight_in_reset");
        idle(2);
        rst_n = 1'b1;
        idle(5);
        check_outputs_idle("inflight_after");
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; log_valid = 1'b0; log_addr = '0;
        repair_en = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        array_rdata = '0;
        m_used = 0; m_fail = 1'b0;
        for (int i = 0; i < 32; i++) begin
            arr_mem[i]   = DATA_W'(i * 7 + 1);
            arr_exp[i]   = DATA_W'(i * 7 + 1);
            spare_exp[i] = '0;
            m_logged[i]  = 1'b0;
        end
        #1;
        test_reset();
        test_miss_read();
        test_dup_log();
        test_overflow();
        test_hit_rw();
        test_clear_log();
        test_back_to_back();
        test_reset_inflight();
        total++;
        if (exp_q.size() != 0) begin
            $display("FAIL outstanding_reads: got %0d pending want 0", exp_q.size());
            bad++;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
